// File: rtl/cm_fifo_sync_ctrl.sv
// cm_fifo_sync_ctrl: first-word-fall-through FIFO controller sequencing an external simple
// dual-port RAM. Sticky ovf/udf flags are built only when CM_FIFO_ERR_FLAG_EN is defined.
module cm_fifo_sync_ctrl #(
    parameter int WIDTH     = 256,
    parameter int SIZE      = 10,
    parameter int AFULL_LVL = 2**SIZE - 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             afull,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [SIZE:0]    level,
    output logic             ovf,
    output logic             udf,
    output logic             ram_ena,
    output logic             ram_wea,
    output logic [SIZE-1:0]  ram_addra,
    output logic [WIDTH-1:0] ram_dia,
    output logic             ram_enb,
    output logic [SIZE-1:0]  ram_addrb,
    input  logic [WIDTH-1:0] ram_dob
);

    localparam logic [SIZE:0] DEPTH_C = {1'b1, {SIZE{1'b0}}};
    localparam logic [SIZE:0] AFULL_C = (SIZE+1)'(AFULL_LVL);
    localparam logic [SIZE:0] ONE_C   = {{SIZE{1'b0}}, 1'b1};

    logic [SIZE:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE:0] rd_ptr_q, rd_ptr_d;
    logic [SIZE:0] level_q, level_d;
    logic          hv_q, hv_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          wr_acc_s, pop_s, ram_avail_s, ram_enb_s;

    // Accept/pop decode, head prefetch and next-state for pointers, level and flags.
    always_comb begin
        wr_acc_s    = wr_en & ~full_q & rst_n;
        pop_s       = rd_en & hv_q;
        ram_avail_s = (wr_ptr_q != rd_ptr_q);
        // Refill the head whenever it is empty or being consumed this cycle.
        ram_enb_s   = ram_avail_s & (~hv_q | pop_s) & rst_n;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        hv_d        = ram_enb_s | (hv_q & ~pop_s);

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (ram_enb_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, pop_s})
            2'b10:   level_d = level_q + ONE_C;
            2'b01:   level_d = level_q - ONE_C;
            default: level_d = level_q;
        endcase

        full_d  = (level_d == DEPTH_C);
        afull_d = (level_d >= AFULL_C);
    end

    // State registers; RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(SIZE+1){1'b0}};
            rd_ptr_q <= {(SIZE+1){1'b0}};
            level_q  <= {(SIZE+1){1'b0}};
            hv_q     <= 1'b0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hv_q     <= hv_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

`ifdef CM_FIFO_ERR_FLAG_EN
    logic ovf_q, udf_q;

    // Sticky error capture; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en & full_q) begin
                ovf_q <= 1'b1;
            end
            if (rd_en & ~hv_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign full      = full_q;
    assign afull     = afull_q;
    assign level     = level_q;
    assign empty     = ~hv_q;
    assign rd_data   = ram_dob;
    assign ram_ena   = wr_acc_s;
    assign ram_wea   = wr_acc_s;
    assign ram_addra = wr_ptr_q[SIZE-1:0];
    assign ram_dia   = wr_data;
    assign ram_enb   = ram_enb_s;
    assign ram_addrb = rd_ptr_q[SIZE-1:0];

endmodule
